// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: streams two WIDTH-bit operands LSB first through an
// external combinational full adder, carrying between cycles and assembling the sum.
module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             fa_a,
    output logic             fa_b,
    output logic             fa_ci,
    input  logic             fa_s,
    input  logic             fa_c,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic [WIDTH-1:0] acc;
    logic             carry;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] acc_next;

    assign acc_next = {fa_s, acc[WIDTH-1:1]};

    // The adder only sees live operand bits while running; it is quiet otherwise.
    assign fa_a  = (state == RUN) & opa[0];
    assign fa_b  = (state == RUN) & opb[0];
    assign fa_ci = (state == RUN) & carry;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            opa   <= '0;
            opb   <= '0;
            acc   <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        opa   <= a;
                        opb   <= b;
                        carry <= cin;
                        cnt   <= '0;
                        acc   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    acc   <= acc_next;
                    carry <= fa_c;
                    opa   <= opa >> 1;
                    opb   <= opb >> 1;
                    cnt   <= cnt + CNT_W'(1);
                    // The edge that consumes the MSB also publishes the result.
                    if (cnt == CNT_LAST) begin
                        sum   <= acc_next;
                        cout  <= fa_c;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Bench for serial_adder_ctrl: WIDTH=8 directed/random/handshake/reset cases and a
// WIDTH=4 exhaustive sweep, both driving a behavioural full adder.
module tb_serial_adder_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       start8 = 1'b0, cin8 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0, sum8;
    logic       fa_a8, fa_b8, fa_ci8, fa_s8, fa_c8, busy8, done8, cout8;

    logic       start4 = 1'b0, cin4 = 1'b0;
    logic [3:0] a4 = '0, b4 = '0, sum4;
    logic       fa_a4, fa_b4, fa_ci4, fa_s4, fa_c4, busy4, done4, cout4;

    assign fa_s8 = fa_a8 ^ fa_b8 ^ fa_ci8;
    assign fa_c8 = (fa_a8 & fa_b8) | (fa_ci8 & (fa_a8 ^ fa_b8));
    assign fa_s4 = fa_a4 ^ fa_b4 ^ fa_ci4;
    assign fa_c4 = (fa_a4 & fa_b4) | (fa_ci4 & (fa_a4 ^ fa_b4));

    serial_adder_ctrl #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .cin(cin8),
        .fa_a(fa_a8), .fa_b(fa_b8), .fa_ci(fa_ci8), .fa_s(fa_s8), .fa_c(fa_c8),
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
    );

    serial_adder_ctrl #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4), .cin(cin4),
        .fa_a(fa_a4), .fa_b(fa_b4), .fa_ci(fa_ci4), .fa_s(fa_s4), .fa_c(fa_c4),
        .busy(busy4), .done(done4), .sum(sum4), .cout(cout4)
    );

    int n_chk = 0;
    int n_fail = 0;
    logic [8:0] last8 = '0;
    logic [4:0] last4 = '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full WIDTH=8 addition from IDLE, checking bit stream, carry, timing and result.
    task automatic op8(input logic [7:0] ai, input logic [7:0] bi, input logic ci);
        logic [8:0] exp;
        logic [8:0] part;
        logic [7:0] mask;
        exp = 9'(ai) + 9'(bi) + 9'(ci);
        chk("idle_busy8", 32'(busy8), 32'd0);
        a8 = ai; b8 = bi; cin8 = ci; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
        for (int k = 0; k < 8; k++) begin
            mask = 8'((9'd1 << k) - 9'd1);
            part = 9'(ai & mask) + 9'(bi & mask) + 9'(ci);
            chk("run_busy8", 32'(busy8), 32'd1);
            chk("run_done8", 32'(done8), 32'd0);
            chk("fa_a8", 32'(fa_a8), 32'(ai[k]));
            chk("fa_b8", 32'(fa_b8), 32'(bi[k]));
            chk("fa_ci8", 32'(fa_ci8), 32'(part >> k));
            chk("hold_res8", 32'({cout8, sum8}), 32'(last8));
            tick();
        end
        chk("done8", 32'(done8), 32'd1);
        chk("res8", 32'({cout8, sum8}), 32'(exp));
        chk("done_fa8", 32'({fa_a8, fa_b8, fa_ci8}), 32'd0);
        last8 = exp;
        tick();
        chk("post_done8", 32'(done8), 32'd0);
        chk("post_busy8", 32'(busy8), 32'd0);
        chk("idle_fa8", 32'({fa_a8, fa_b8, fa_ci8}), 32'd0);
        chk("idle_res8", 32'({cout8, sum8}), 32'(last8));
    endtask

    task automatic op4(input logic [8:0] v);
        logic [4:0] exp;
        exp = 5'(v[3:0]) + 5'(v[7:4]) + 5'(v[8]);
        a4 = v[3:0]; b4 = v[7:4]; cin4 = v[8]; start4 = 1'b1;
        tick();
        start4 = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk("run_done4", 32'(done4), 32'd0);
            chk("hold_res4", 32'({cout4, sum4}), 32'(last4));
            tick();
        end
        chk("done4", 32'(done4), 32'd1);
        chk("res4", 32'({cout4, sum4}), 32'(exp));
        last4 = exp;
        tick();
        chk("post_done4", 32'({busy4, done4}), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int starts[$];
        logic [8:0] res[$];
        logic prevb;

        repeat (3) tick();
        chk("rst_busy", 32'(busy8), 32'd0);
        chk("rst_done", 32'(done8), 32'd0);
        chk("rst_res", 32'({cout8, sum8}), 32'd0);
        chk("rst_fa", 32'({fa_a8, fa_b8, fa_ci8}), 32'd0);
        rst_n = 1'b1;
        tick();

        op8(8'h5A, 8'h3C, 1'b0);
        op8(8'hFF, 8'h01, 1'b0);
        op8(8'hFF, 8'h00, 1'b1);
        op8(8'h00, 8'h00, 1'b0);
        op8(8'hFF, 8'hFF, 1'b1);
        repeat (20) op8(8'($urandom), 8'($urandom), 1'($urandom));

        // start held high: accepted starts must be WIDTH+2 apart, operands captured at start
        a8 = 8'h10; b8 = 8'h20; cin8 = 1'b0; start8 = 1'b1;
        prevb = busy8;
        for (int c = 0; c < 24; c++) begin
            tick();
            if (busy8 && !prevb) begin
                starts.push_back(c);
                if (starts.size() == 2) start8 = 1'b0;
            end
            if (c == 3) begin a8 = 8'hFF; b8 = 8'hFF; end
            if (done8) res.push_back({cout8, sum8});
            prevb = busy8;
        end
        start8 = 1'b0;
        chk("hold_nstarts", 32'(starts.size()), 32'd2);
        if (starts.size() == 2) chk("hold_gap", 32'(starts[1] - starts[0]), 32'd10);
        chk("hold_nres", 32'(res.size()), 32'd2);
        if (res.size() >= 1) chk("hold_res0", 32'(res[0]), 32'h030);
        if (res.size() >= 2) chk("hold_res1", 32'(res[1]), 32'h1FE);
        last8 = 9'h1FE;
        tick();

        // reset after three processed bits discards the operation
        a8 = 8'hAB; b8 = 8'hCD; cin8 = 1'b1; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        repeat (3) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("mid_rst_busy", 32'(busy8), 32'd0);
        chk("mid_rst_done", 32'(done8), 32'd0);
        chk("mid_rst_res", 32'({cout8, sum8}), 32'd0);
        chk("mid_rst_fa", 32'({fa_a8, fa_b8, fa_ci8}), 32'd0);
        last8 = '0;
        for (int c = 0; c < 12; c++) begin
            tick();
            chk("no_done_after_rst", 32'({busy8, done8}), 32'd0);
        end
        op8(8'h01, 8'h01, 1'b0);

        for (int i = 0; i < 512; i++) op4(9'(i));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/serial_adder_ctrl.md
# serial_adder_ctrl

Bit-serial adder controller that drives the team's 1-bit full adder, `fulladder`, to add two WIDTH-bit operands one bit per clock, LSB first. It sits directly upstream of the full adder, feeding its `a`, `b` and `ci` inputs. It also sits downstream, consuming `s` and `c`. The controller provides operand loading, carry storage between cycles, sum assembly and a start/done handshake.

## Interface
Parameters:
- WIDTH, default 8: operand and sum width in bits; legal range WIDTH >= 2.

Ports:
- clk  input  1  sole clock; all state updates on rising edge.
- rst_n  input  1  synchronous, active-low reset, sampled on rising edge of clk.
- start  input  1  request to begin an addition; sampled only in IDLE.
- a  input  WIDTH  operand A; captured on accepted start.
- b  input  WIDTH  operand B; captured on accepted start.
- cin  input  1  carry-in; captured on accepted start.
- fa_a  output  1  to full adder `a`.
- fa_b  output  1  to full adder `b`.
- fa_ci  output  1  to full adder `ci`.
- fa_s  input  1  from full adder `s` (combinational sum bit).
- fa_c  input  1  from full adder `c` (combinational carry-out).
- busy  output  1  high in RUN and DONE.
- done  output  1  one-cycle pulse in DONE.
- sum  output  WIDTH  registered result of the last completed addition.
- cout  output  1  registered carry-out of the last completed addition.

## Operation
- Internal registers:
  - opa, opb: WIDTH bits each, right-shifting operand copies.
  - carry: 1 bit.
  - acc: WIDTH bits, sum shift register.
  - cnt: $clog2(WIDTH) bits.
  - state: one of IDLE, RUN, DONE.
- fa_a = opa[0], fa_b = opb[0], fa_ci = carry, all while in RUN. In IDLE and DONE, all three outputs are 0.
- IDLE:
  - With start = 1: opa <= a, opb <= b, carry <= cin, cnt <= 0, acc <= 0; go to RUN.
  - With start = 0: stay in IDLE.
- RUN, on each cycle:
  - acc <= {fa_s, acc[WIDTH-1:1]}.
  - carry <= fa_c.
  - opa <= opa >> 1, opb <= opb >> 1.
  - cnt <= cnt + 1.
  - When cnt == WIDTH-1, the current edge processes the final bit. At that edge, sum <= {fa_s, acc[WIDTH-1:1]} and cout <= fa_c; go to DONE.
- DONE: done = 1 for exactly one cycle, then unconditionally go to IDLE.
- start is ignored in RUN and DONE; it is neither queued nor latched.
- a, b and cin may change freely after the start edge without affecting the operation in progress.
- sum and cout change only on the RUN→DONE edge. They hold their values through IDLE and through the next operation until that operation completes.
- Arithmetic: {cout, sum} = a + b + cin, modulo 2^(WIDTH+1); no overflow flag.
- Reset (rst_n = 0 at an edge), in any state including mid-RUN:
  - state <= IDLE.
  - opa, opb, acc, sum, cnt <= 0; carry, cout <= 0.
  - done and busy are 0 in the following cycle.
  - The partial result is discarded; no done pulse is produced.
- The block assumes the downstream full adder is purely combinational: fa_s and fa_c are valid in the same cycle as fa_a, fa_b and fa_ci.

## Timing
- Start accepted at edge E0: RUN occupies cycles E0+1 through E0+WIDTH, one bit per cycle.
- At edge E0+WIDTH, sum and cout become valid and the state is DONE.
- done is high during the cycle after edge E0+WIDTH.
- Total latency from start edge to done edge: WIDTH+1 cycles.
- Earliest next accepted start: the edge where the state has returned to IDLE, i.e. E0+WIDTH+2.
- Throughput: one addition per WIDTH+2 cycles.
- busy rises in the cycle after E0 and falls in the cycle after the done pulse.
- Output values after reset: busy = 0, done = 0, sum = 0, cout = 0, fa_a = fa_b = fa_ci = 0.

## Test plan
- WIDTH = 8, a = 0x5A, b = 0x3C, cin = 0 → sum = 0x96, cout = 0. done pulses exactly 9 cycles after the start edge. fa_a/fa_b sequence observed LSB first: 0,1,0,1,1,0,1,0 / 0,0,1,1,1,1,0,0.
- a = 0xFF, b = 0x01, cin = 0 → sum = 0x00, cout = 1. a = 0xFF, b = 0x00, cin = 1 → sum = 0x00, cout = 1. a = 0x00, b = 0x00, cin = 0 → sum = 0x00, cout = 0.
- start held high continuously with a = 0x10, b = 0x20; change a and b to 0xFF mid-RUN → first result is sum = 0x30. Accepted starts are exactly WIDTH+2 cycles apart. The second operation uses 0xFF + 0xFF → sum = 0xFE, cout = 1.
- rst_n = 0 for one cycle during RUN (after 3 bits) → no done pulse; busy = 0 and sum = 0 on the next cycle. A fresh start with a = 0x01, b = 0x01, cin = 0 then completes normally → sum = 0x02, cout = 0.
- Exhaustive sweep, WIDTH = 4: all 512 combinations of {a, b, cin}. Each result is compared against a + b + cin. sum and cout stay stable between done pulses.
